fifo_wr_arb: RTL
================

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of one word.
REQ-002 SHALL have parameter FIFO_DEPTH, default 32, word capacity of the downstream N-to-M FIFO.
REQ-003 SHALL have parameter N, default 4, maximum words per FIFO write.
REQ-004 SHALL have parameter NUM_REQ, default 4, number of requesters.
REQ-005 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1, reset; reset is synchronous and active-high.
REQ-007 SHALL have port req_valid, input, NUM_REQ, per-requester beat valid.
REQ-008 SHALL have port req_cnt, input, NUM_REQ x CW (CW = $clog2(N+1)), words in beat, 0..N.
REQ-009 SHALL have port req_data, input, NUM_REQ x N x DATA_WIDTH, beat words, index 0 written first.
REQ-010 SHALL have port req_last, input, NUM_REQ, beat closes the requester's burst.
REQ-011 SHALL have port req_ready, output, NUM_REQ, beat accepted this cycle when valid & ready.
REQ-012 SHALL have port fifo_wr_data, output, N x DATA_WIDTH, registered write words to the FIFO.
REQ-013 SHALL have port fifo_wr_cnt, output, CW, registered word count to write; 0 = no write.
REQ-014 SHALL have port fifo_rd_cnt, input, CW, words popped from the FIFO this cycle.
REQ-015 SHALL have port credits, output, $clog2(FIFO_DEPTH+1), free FIFO slots tracked.
REQ-016 SHALL have port grant_id, output, $clog2(NUM_REQ), requester currently granted/locked.
REQ-017 SHALL have port credit_err, output, 1, sticky credit overflow flag.
REQ-018 SHALL have port stall_cnt, output, 16, arbitration stall counter (see Configuration).

Function
REQ-019 SHALL run FSM states IDLE (free arbitration) and LOCKED (grant held by grant_id).
REQ-020 IDLE: eligible = req_valid & (req_cnt <= credits); SHALL grant one eligible requester, round-robin starting at rr_ptr.
REQ-021 LOCKED: SHALL assert req_ready only for grant_id, only when req_cnt <= credits; no skipping to others.
REQ-022 At most one req_ready bit SHALL be high per cycle; req_ready SHALL be combinational from inputs and state.
REQ-023 Accepted beat with req_last=0 SHALL move FSM to (or keep) LOCKED with grant_id = accepted requester.
REQ-024 Accepted beat with req_last=1 SHALL return FSM to IDLE and set rr_ptr = grantee+1 modulo NUM_REQ.
REQ-025 Accepted beat SHALL appear on fifo_wr_data/fifo_wr_cnt exactly one cycle later; otherwise fifo_wr_cnt = 0.
REQ-026 Accepted beat with req_cnt = 0 SHALL be legal: no words written, req_last still honoured.
REQ-027 credits next = credits - accepted req_cnt + fifo_rd_cnt, updated at acceptance (not at registered write).
REQ-028 Simultaneous accept and fifo_rd_cnt SHALL both apply in the same cycle.
REQ-029 If credits + fifo_rd_cnt - accepted cnt > FIFO_DEPTH, credits SHALL saturate at FIFO_DEPTH and credit_err SHALL set until reset.
REQ-030 credits = 0 SHALL block every beat with req_cnt > 0; zero-count beats stay acceptable.

Reset
REQ-031 Reset SHALL give: FSM IDLE, rr_ptr 0, grant_id 0, credits FIFO_DEPTH, fifo_wr_cnt 0, fifo_wr_data 0, credit_err 0, stall_cnt 0, req_ready all 0.
REQ-032 Reset asserted mid-burst SHALL drop the lock; any beat accepted in the reset cycle SHALL be discarded.

Configuration
REQ-033 Macro WR_ARB_STATS_EN defined: stall_cnt SHALL increment, saturating at 16'hFFFF, each cycle with any req_valid high and no acceptance.
REQ-034 Macro not defined: stall_cnt SHALL be constant 0 and no counter logic SHALL be built.

Structure
REQ-035 Package wr_arb_pkg SHALL hold the word typedef, count-width function, and FSM state enum.
REQ-036 Round-robin selection SHALL be sub-module rr_arbiter (request vector + pointer in, one-hot grant out).

Verification
REQ-037 Reset, no traffic -> credits=32, fifo_wr_cnt=0, all req_ready=0, stall_cnt=0.
REQ-038 Req0..3 all valid, cnt=1, last=1, 8 cycles -> grants 0,1,2,3,0,1,2,3; credits 32->24; each word on fifo_wr_data one cycle after acceptance.
REQ-039 Req1 beats cnt=4 last=0,0,1 while req2 valid -> req2 blocked until req1's last beat; then req2 granted next.
REQ-040 credits=3, req0 cnt=4, req1 cnt=2 -> req1 granted, req0 stalls; fifo_rd_cnt=4 next cycle -> req0 granted.
REQ-041 fifo_rd_cnt=2 at credits=32 -> credits stays 32, credit_err=1 until reset.
REQ-042 WR_ARB_STATS_EN defined, req0 valid cnt=4, credits=0 for 10 cycles -> stall_cnt=10; undefined -> 0.

Source files
------------

// File: rtl/wr_arb_pkg.sv
// Shared types for the FIFO write arbiter: word type, count-width helper, FSM states.
package wr_arb_pkg;

  localparam int WORD_W = 8;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } arb_state_t;

  // Bits needed to hold a count in the range 0..max_cnt.
  function automatic int cnt_width(input int max_cnt);
    return $clog2(max_cnt + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set request at or after ptr (wrapping) wins, one-hot grant.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt
);

  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[(int'(ptr) + i) % NUM_REQ]) begin
        gnt[(int'(ptr) + i) % NUM_REQ] = 1'b1;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Credit-tracked, burst-locking round-robin write arbiter in front of an N-to-M FIFO.
// Optional stall statistics counter built only when WR_ARB_STATS_EN is defined.
//
// state     | meaning
// ST_IDLE   | free round-robin arbitration among eligible requesters
// ST_LOCKED | burst in progress; only grant_id may be accepted
module fifo_wr_arb
  import wr_arb_pkg::*;
#(
  parameter int  DATA_WIDTH = WORD_W,
  parameter int  FIFO_DEPTH = 32,
  parameter int  N          = 4,
  parameter int  NUM_REQ    = 4,
  localparam int CW         = cnt_width(N),
  localparam int CRW        = cnt_width(FIFO_DEPTH),
  localparam int IW         = $clog2(NUM_REQ)
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [NUM_REQ-1:0]                         req_valid,
  input  logic [NUM_REQ-1:0][CW-1:0]                 req_cnt,
  input  logic [NUM_REQ-1:0][N-1:0][DATA_WIDTH-1:0]  req_data,
  input  logic [NUM_REQ-1:0]                         req_last,
  output logic [NUM_REQ-1:0]                         req_ready,
  output logic [N-1:0][DATA_WIDTH-1:0]               fifo_wr_data,
  output logic [CW-1:0]                              fifo_wr_cnt,
  input  logic [CW-1:0]                              fifo_rd_cnt,
  output logic [CRW-1:0]                             credits,
  output logic [IW-1:0]                              grant_id,
  output logic                                       credit_err,
  output logic [15:0]                                stall_cnt
);

  localparam int             SW      = CRW + 1;
  localparam logic [SW-1:0]  DEPTH_S = SW'(FIFO_DEPTH);
  localparam logic [CRW-1:0] DEPTH_C = CRW'(FIFO_DEPTH);

  arb_state_t         state, state_nxt;
  logic [IW-1:0]      rr_ptr, rr_ptr_nxt, grant_nxt;
  logic [NUM_REQ-1:0] elig, rr_gnt;
  logic               acc, acc_last;
  logic [IW-1:0]      acc_idx;
  logic [CW-1:0]      acc_cnt;
  logic [SW-1:0]      cred_sum;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_valid[i] && (SW'(req_cnt[i]) <= SW'(credits));
    end
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req (elig),
    .ptr (rr_ptr),
    .gnt (rr_gnt)
  );

  // Ready is held low during reset so nothing can be accepted in that cycle.
  always_comb begin
    req_ready = '0;
    if (!rst) begin
      if (state == ST_IDLE) req_ready = rr_gnt;
      else                  req_ready[grant_id] = elig[grant_id];
    end
  end

  always_comb begin
    acc     = |req_ready;
    acc_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) acc_idx = IW'(i);
    end
    acc_cnt  = acc ? req_cnt[acc_idx] : '0;
    acc_last = req_last[acc_idx];
  end

  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    grant_nxt  = grant_id;
    if (acc) begin
      grant_nxt = acc_idx;
      if (acc_last) begin
        state_nxt  = ST_IDLE;
        rr_ptr_nxt = (acc_idx == IW'(NUM_REQ - 1)) ? '0 : acc_idx + IW'(1);
      end else begin
        state_nxt = ST_LOCKED;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_ptr_nxt;
      grant_id <= grant_nxt;
    end
  end

  // acc_cnt never exceeds credits, so only the upper bound can be violated.
  assign cred_sum = SW'(credits) + SW'(fifo_rd_cnt) - SW'(acc_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      credits      <= DEPTH_C;
      credit_err   <= 1'b0;
      fifo_wr_cnt  <= '0;
      fifo_wr_data <= '0;
    end else begin
      fifo_wr_cnt <= acc_cnt;
      if (acc) fifo_wr_data <= req_data[acc_idx];
      if (cred_sum > DEPTH_S) begin
        credits    <= DEPTH_C;
        credit_err <= 1'b1;
      end else begin
        credits <= cred_sum[CRW-1:0];
      end
    end
  end

`ifdef WR_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if ((|req_valid) && !acc && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`else
  assign stall_cnt = '0;
`endif

endmodule
